// File: rtl/rx_frame_sr.sv
// rtl/rx_frame_sr.sv - UART receive framing shift register with parity/framing checks
module rx_frame_sr #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 shift_strobe,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] packet_data,
   output logic                 stop_bit,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int FRAME_BITS = DATA_BITS + PARITY_EN + 1;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      count, count_nxt;
   logic [FRAME_BITS-1:0] frame, frame_nxt;
   logic                  publish;
   logic                  parity_fail;

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      frame_nxt = frame;
      publish   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
               count_nxt = '0;
            end
         end
         SHIFT: begin
            // start re-arms the frame and swallows any coincident strobe
            if (start) begin
               count_nxt = '0;
            end else if (shift_strobe) begin
               frame_nxt = {serial_in, frame[FRAME_BITS-1:1]};
               count_nxt = count + 1'b1;
               if (count_nxt == LAST_COUNT) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            publish = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
               count_nxt = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // frame[DATA_BITS] is the parity bit when enabled; data bits sit below it
   always_comb begin
      parity_fail = 1'b0;
      if (PARITY_EN != 0) begin
         parity_fail = (^frame[DATA_BITS:0]) ^ (PARITY_ODD != 0);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         count         <= '0;
         frame         <= '0;
         packet_data   <= '0;
         stop_bit      <= 1'b1;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         frame      <= frame_nxt;
         frame_done <= publish;
         if (publish) begin
            packet_data   <= frame[DATA_BITS-1:0];
            stop_bit      <= frame[FRAME_BITS-1];
            parity_error  <= parity_fail;
            framing_error <= ~frame[FRAME_BITS-1];
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rx_frame_sr.sv
// tb/tb_rx_frame_sr.sv - randomized bench for rx_frame_sr in three parameter configurations
module tb_rx_frame_sr;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic start = 1'b0;
   logic shift_strobe = 1'b0;
   logic serial_in = 1'b0;

   always #5 clk = ~clk;

   // a: D=8 no parity, b: D=7 even, c: D=7 odd -- all share a 9-bit frame
   logic [7:0] pd_a;
   logic [6:0] pd_b, pd_c;
   logic stop_a, stop_b, stop_c, perr_a, perr_b, perr_c;
   logic ferr_a, ferr_b, ferr_c, fd_a, fd_b, fd_c, busy_a, busy_b, busy_c;

   rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
      .clk(clk), .n_rst(n_rst), .start(start), .shift_strobe(shift_strobe), .serial_in(serial_in),
      .packet_data(pd_a), .stop_bit(stop_a), .parity_error(perr_a), .framing_error(ferr_a),
      .frame_done(fd_a), .busy(busy_a));
   rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
      .clk(clk), .n_rst(n_rst), .start(start), .shift_strobe(shift_strobe), .serial_in(serial_in),
      .packet_data(pd_b), .stop_bit(stop_b), .parity_error(perr_b), .framing_error(ferr_b),
      .frame_done(fd_b), .busy(busy_b));
   rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
      .clk(clk), .n_rst(n_rst), .start(start), .shift_strobe(shift_strobe), .serial_in(serial_in),
      .packet_data(pd_c), .stop_bit(stop_c), .parity_error(perr_c), .framing_error(ferr_c),
      .frame_done(fd_c), .busy(busy_c));

   logic [7:0] obs_pd[3];
   logic obs_stop[3], obs_perr[3], obs_ferr[3], obs_fd[3], obs_busy[3];
   assign obs_pd[0] = pd_a;
   assign obs_pd[1] = {1'b0, pd_b};
   assign obs_pd[2] = {1'b0, pd_c};
   assign obs_stop = '{stop_a, stop_b, stop_c};
   assign obs_perr = '{perr_a, perr_b, perr_c};
   assign obs_ferr = '{ferr_a, ferr_b, ferr_c};
   assign obs_fd   = '{fd_a, fd_b, fd_c};
   assign obs_busy = '{busy_a, busy_b, busy_c};

   logic [7:0] exp_pd[3];
   logic exp_stop[3], exp_perr[3], exp_ferr[3];

   int checks = 0;
   int failures = 0;
   int fd_cnt[3] = '{0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (obs_fd[i]) fd_cnt[i]++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         exp_pd[i] = 8'h00; exp_stop[i] = 1'b1; exp_perr[i] = 1'b0; exp_ferr[i] = 1'b0;
      end
   endtask

   // bits[i] is the i-th bit received on the line
   task automatic model_publish(input logic [8:0] bits);
      int ones;
      ones = $countones(bits[7:0]);
      exp_pd[0] = bits[7:0];
      exp_pd[1] = {1'b0, bits[6:0]};
      exp_pd[2] = {1'b0, bits[6:0]};
      for (int i = 0; i < 3; i++) begin
         exp_stop[i] = bits[8];
         exp_ferr[i] = ~bits[8];
      end
      exp_perr[0] = 1'b0;
      exp_perr[1] = (ones % 2) == 1;
      exp_perr[2] = (ones % 2) == 0;
   endtask

   task automatic check_outputs(input string where);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_pd%0d", where, i), 32'(obs_pd[i]), 32'(exp_pd[i]));
         check($sformatf("%s_stop%0d", where, i), 32'(obs_stop[i]), 32'(exp_stop[i]));
         check($sformatf("%s_perr%0d", where, i), 32'(obs_perr[i]), 32'(exp_perr[i]));
         check($sformatf("%s_ferr%0d", where, i), 32'(obs_ferr[i]), 32'(exp_ferr[i]));
      end
   endtask

   task automatic check_ctrl(input string where, input logic fd_exp, input logic busy_exp);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_fd%0d", where, i), 32'(obs_fd[i]), 32'(fd_exp));
         check($sformatf("%s_busy%0d", where, i), 32'(obs_busy[i]), 32'(busy_exp));
      end
   endtask

   task automatic shift_bit(input logic b, input int max_gap);
      repeat ($urandom_range(max_gap, 0)) tick();
      shift_strobe = 1'b1;
      serial_in = b;
      tick();
      shift_strobe = 1'b0;
   endtask

   task automatic pulse_start(input logic collide);
      start = 1'b1;
      shift_strobe = collide;
      serial_in = 1'($urandom);
      tick();
      start = 1'b0;
      shift_strobe = 1'b0;
   endtask

   task automatic do_frame(input string tag, input logic [8:0] bits, input int max_gap,
                           input logic collide, input logic do_start, input logic start_in_done);
      if (do_start) pulse_start(collide);
      for (int i = 0; i < 9; i++) shift_bit(bits[i], max_gap);
      check_ctrl({tag, "_done"}, 1'b0, 1'b1);
      start = start_in_done;
      shift_strobe = 1'($urandom);
      serial_in = 1'($urandom);
      tick();
      start = 1'b0;
      shift_strobe = 1'b0;
      model_publish(bits);
      check_ctrl({tag, "_pub"}, 1'b1, start_in_done);
      check_outputs(tag);
      if (!start_in_done) begin
         tick();
         check_ctrl({tag, "_after"}, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int snap[3];
      logic sid;
      logic [8:0] rbits;

      model_reset();
      repeat (2) tick();
      check_ctrl("reset", 1'b0, 1'b0);
      check_outputs("reset");
      n_rst = 1'b1;
      tick();

      do_frame("a5_stop1", {1'b1, 8'hA5}, 0, 1'b0, 1'b1, 1'b0);
      do_frame("a5_stop0", {1'b0, 8'hA5}, 2, 1'b0, 1'b1, 1'b0);
      do_frame("41_par0", {1'b1, 1'b0, 7'h41}, 1, 1'b0, 1'b1, 1'b0);
      do_frame("41_par1", {1'b1, 1'b1, 7'h41}, 1, 1'b1, 1'b1, 1'b0);

      snap = fd_cnt;
      pulse_start(1'b0);
      for (int i = 0; i < 4; i++) shift_bit(1'($urandom), 1);
      do_frame("abort_3c", {1'b1, 8'h3C}, 1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) check($sformatf("abort_cnt%0d", i), 32'(fd_cnt[i] - snap[i]), 32'd1);

      pulse_start(1'b0);
      for (int i = 0; i < 5; i++) shift_bit(1'($urandom), 1);
      n_rst = 1'b0;
      #1;
      model_reset();
      check_ctrl("midrst", 1'b0, 1'b0);
      check_outputs("midrst");
      tick();
      n_rst = 1'b1;
      snap = fd_cnt;
      for (int i = 0; i < 12; i++) begin
         shift_strobe = 1'b1;
         serial_in = 1'($urandom);
         tick();
         check_ctrl("nostart", 1'b0, 1'b0);
      end
      shift_strobe = 1'b0;
      check_outputs("nostart");
      for (int i = 0; i < 3; i++) check($sformatf("nostart_cnt%0d", i), 32'(fd_cnt[i] - snap[i]), 32'd0);

      do_frame("b2b_first", {1'b1, 8'hC3}, 1, 1'b0, 1'b1, 1'b1);
      do_frame("b2b_5a", {1'b1, 8'h5A}, 1, 1'b0, 1'b0, 1'b0);

      sid = 1'b0;
      for (int f = 0; f < 40; f++) begin
         if (!sid) begin
            repeat ($urandom_range(3, 0)) begin
               shift_strobe = 1'($urandom);
               serial_in = 1'($urandom);
               tick();
            end
            shift_strobe = 1'b0;
            if ($urandom_range(4, 0) == 0) begin
               pulse_start(1'($urandom));
               for (int k = $urandom_range(8, 1); k > 0; k--) shift_bit(1'($urandom), 1);
            end
         end
         rbits = 9'($urandom);
         do_frame($sformatf("rnd%0d", f), rbits, 2, 1'($urandom), !sid || ($urandom_range(1, 0) == 1),
                  ($urandom_range(3, 0) == 0));
         sid = obs_busy[0];
      end
      if (sid) begin
         repeat (12) shift_bit(1'b1, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
